bus_busy_responder: RTL and testbench

- Module-side responder on a clock-domain-crossed CPU bus segment.
- It decodes the single-cycle pulsed bus requests delivered in its local clock domain and stretches each access with module_busy_o.
- The busy falling edge is the completion event the bus bridge uses to return read data to the CPU domain.
- It provides a scratch register, a blocking-read FIFO mailbox fed by local logic, and a status/clear register. The CDC entry for this block must have busy-enable set to 1.

---
 rtl/cpu_reg_package.sv | 33 +++
 rtl/sync_fifo.sv | 63 ++++++
 rtl/bus_busy_responder.sv | 210 +++++++++++++++++++++
 tb/tb_bus_busy_responder.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_reg_package.sv
`default_nettype none
// ============================================================================
// Module      : cpu_reg_package
// Description : Shared CPU-bus widths, responder register map, STATUS bit
//               positions and the responder FSM state type.
// Revision    : 1.0  initial release
// ============================================================================
package cpu_reg_package;

    localparam int address_width = 32;
    localparam int data_width    = 32;

    // Responder register offsets relative to the block base address
    localparam logic [3:0] OFF_SCRATCH   = 4'h0;
    localparam logic [3:0] OFF_FIFO_DATA = 4'h4;
    localparam logic [3:0] OFF_STATUS    = 4'h8;
    localparam logic [3:0] OFF_CLEAR     = 4'hC;

    localparam int ST_EMPTY_BIT    = 0;
    localparam int ST_FULL_BIT     = 1;
    localparam int ST_TIMEOUT_BIT  = 2;
    localparam int ST_OVERRUN_BIT  = 3;
    localparam int ST_COUNT_LSB    = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        BLOCK = 2'd2,
        DONE  = 2'd3
    } responder_state_t;

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock show-ahead FIFO; head word is visible on data
//               whenever the FIFO is not empty.
// Revision    : 1.0  initial release
// ============================================================================
module sync_fifo #(
    parameter int DataWidth = 32,
    parameter int Depth     = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [DataWidth-1:0]         push_data,
    input  logic                         pop,
    output logic [DataWidth-1:0]         data,
    output logic                         empty,
    output logic                         full,
    output logic [$clog2(Depth+1)-1:0]   count
);

    localparam int PtrW   = $clog2(Depth);
    localparam int CountW = $clog2(Depth + 1);

    logic [DataWidth-1:0] r_mem [Depth];
    logic [PtrW-1:0]      r_wr_ptr;
    logic [PtrW-1:0]      r_rd_ptr;
    logic [CountW-1:0]    r_count;
    logic                 w_push;
    logic                 w_pop;

    assign w_push = push && !full;
    assign w_pop  = pop && !empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: occupancy alone defines which words are valid
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= push_data;
    end

    assign data  = r_mem[r_rd_ptr];
    assign empty = (r_count == '0);
    assign full  = (r_count == CountW'(Depth));
    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/bus_busy_responder.sv
`default_nettype none
// ============================================================================
// Module      : bus_busy_responder
// Description : Busy-stretching bus responder with scratch, blocking-read
//               mailbox FIFO and status/clear registers.
// Revision    : 1.0  initial release
// ============================================================================
module bus_busy_responder
    import cpu_reg_package::*;
#(
    parameter logic [address_width-1:0] BaseAddress   = 32'h0000_9000,
    parameter int                       WaitCycles    = 2,
    parameter int                       FifoDepth     = 8,
    parameter int                       TimeoutCycles = 1024
) (
    input  logic                             clk_i,
    input  logic                             reset_i,
    input  logic [address_width-1:0]         address_i,
    input  logic [data_width-1:0]            data_i,
    input  logic                             we_i,
    input  logic [3:0]                       we_ram_i,
    output logic [data_width-1:0]            data_o,
    output logic                             module_busy_o,
    input  logic                             push_valid_i,
    input  logic [data_width-1:0]            push_data_i,
    output logic                             push_ready_o,
    output logic [$clog2(FifoDepth+1)-1:0]   fifo_count_o
);

    localparam int CountW = $clog2(FifoDepth + 1);
    localparam int CntMax = (TimeoutCycles > WaitCycles) ? TimeoutCycles : WaitCycles;
    localparam int CntW   = $clog2(CntMax + 1);
    localparam logic [CntW-1:0] WaitLast    = CntW'(WaitCycles - 1);
    localparam logic [CntW-1:0] TimeoutLast = CntW'(TimeoutCycles);

    responder_state_t        r_state;
    responder_state_t        w_state_next;
    logic [CntW-1:0]         r_cnt;
    logic [CntW-1:0]         w_cnt_next;
    logic                    r_busy;
    logic                    w_busy_next;
    logic [data_width-1:0]   r_data;
    logic [data_width-1:0]   w_data_next;

    logic [3:0]              r_req_off;
    logic                    r_req_we;
    logic [data_width-1:0]   r_scratch;
    logic                    r_timeout;
    logic                    r_overrun;

    logic [address_width-1:0] w_off;
    logic [3:0]              w_req_off;
    logic                    w_hit;
    logic                    w_accept;
    logic                    w_overrun;
    logic                    w_fifo_rd;
    logic                    w_pop;
    logic                    w_set_timeout;
    logic [data_width-1:0]   w_status;

    logic                    w_fifo_push;
    logic [data_width-1:0]   w_fifo_data;
    logic                    w_fifo_empty;
    logic                    w_fifo_full;
    logic [CountW-1:0]       w_fifo_count;

    // Unsigned wrap makes addresses below the base fall out of range
    assign w_off     = address_i - BaseAddress;
    assign w_hit     = (w_off <= address_width'(OFF_CLEAR));
    assign w_req_off = {w_off[3:2], 2'b00};
    assign w_accept  = w_hit && (r_state == IDLE);
    assign w_overrun = w_hit && (r_state != IDLE);
    assign w_fifo_rd = !r_req_we && (r_req_off == OFF_FIFO_DATA);

    always_comb begin
        w_status                          = '0;
        w_status[ST_EMPTY_BIT]            = w_fifo_empty;
        w_status[ST_FULL_BIT]             = w_fifo_full;
        w_status[ST_TIMEOUT_BIT]          = r_timeout;
        w_status[ST_OVERRUN_BIT]          = r_overrun;
        w_status[ST_COUNT_LSB +: 8]       = 8'(w_fifo_count);
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_data  <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_busy  <= w_busy_next;
            r_data  <= w_data_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            IDLE: begin
                if (w_hit) begin
                    w_state_next = WAIT;
                    w_cnt_next   = '0;
                end
            end
            WAIT: begin
                if (r_cnt == WaitLast) begin
                    w_cnt_next   = '0;
                    w_state_next = (w_fifo_rd && w_fifo_empty) ? BLOCK : DONE;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            BLOCK: begin
                if (!w_fifo_empty || (r_cnt == TimeoutLast)) begin
                    w_state_next = DONE;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        w_busy_next   = (w_state_next == WAIT) || (w_state_next == BLOCK);
        w_data_next   = r_data;
        w_pop         = 1'b0;
        w_set_timeout = 1'b0;
        if (w_accept) begin
            w_data_next = '0;
        end else if ((r_state == WAIT) && (w_state_next == DONE)) begin
            if (!r_req_we) begin
                case (r_req_off)
                    OFF_SCRATCH: w_data_next = r_scratch;
                    OFF_FIFO_DATA: begin
                        w_data_next = w_fifo_data;
                        w_pop       = 1'b1;
                    end
                    OFF_STATUS:  w_data_next = w_status;
                    default:     w_data_next = '0;
                endcase
            end
        end else if (r_state == BLOCK) begin
            if (!w_fifo_empty) begin
                w_data_next = w_fifo_data;
                w_pop       = 1'b1;
            end else if (r_cnt == TimeoutLast) begin
                w_data_next   = '0;
                w_set_timeout = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_req_off <= '0;
            r_req_we  <= 1'b0;
            r_scratch <= '0;
            r_timeout <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (w_accept) begin
                r_req_off <= w_req_off;
                r_req_we  <= we_i;
            end
            // An all-zero lane mask on a write means a full-word write
            if (w_accept && we_i && (w_req_off == OFF_SCRATCH)) begin
                for (int b = 0; b < 4; b++) begin
                    if (we_ram_i[b] || (we_ram_i == 4'b0000)) begin
                        r_scratch[8*b +: 8] <= data_i[8*b +: 8];
                    end
                end
            end
            if (w_accept && we_i && (w_req_off == OFF_CLEAR)) begin
                if (data_i[ST_TIMEOUT_BIT]) r_timeout <= 1'b0;
                if (data_i[ST_OVERRUN_BIT]) r_overrun <= 1'b0;
            end
            if (w_set_timeout) r_timeout <= 1'b1;
            if (w_overrun)     r_overrun <= 1'b1;
        end
    end

    assign w_fifo_push = push_valid_i && !w_fifo_full;

    sync_fifo #(
        .DataWidth (data_width),
        .Depth     (FifoDepth)
    ) u_fifo (
        .clk       (clk_i),
        .rst       (reset_i),
        .push      (w_fifo_push),
        .push_data (push_data_i),
        .pop       (w_pop),
        .data      (w_fifo_data),
        .empty     (w_fifo_empty),
        .full      (w_fifo_full),
        .count     (w_fifo_count)
    );

    assign data_o        = r_data;
    assign module_busy_o = r_busy;
    assign push_ready_o  = !w_fifo_full;
    assign fifo_count_o  = w_fifo_count;

endmodule
`default_nettype wire

// File: tb/tb_bus_busy_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_bus_busy_responder
// Description : Self-checking bench for bus_busy_responder against a
//               transaction-level model of the register map and mailbox.
// Revision    : 1.0  initial release
// ============================================================================
module tb_bus_busy_responder;

    localparam logic [31:0] BASE     = 32'h0000_9000;
    localparam int          WAIT_CYC = 2;
    localparam int          DEPTH    = 8;
    localparam int          TOUT     = 16;

    logic        clk = 1'b0;
    logic        reset_i = 1'b1;
    logic [31:0] address_i = '0;
    logic [31:0] data_i = '0;
    logic        we_i = 1'b0;
    logic [3:0]  we_ram_i = '0;
    logic [31:0] data_o;
    logic        module_busy_o;
    logic        push_valid_i = 1'b0;
    logic [31:0] push_data_i = '0;
    logic        push_ready_o;
    logic [3:0]  fifo_count_o;

    int          n_checks = 0;
    int          n_pass = 0;
    bit          checking = 1'b0;
    bit          exp_busy = 1'b0;
    logic [31:0] exp_data = '0;
    logic [31:0] model_q[$];
    logic [31:0] m_scratch = '0;
    bit          m_tout = 1'b0;
    bit          m_ovr = 1'b0;
    int          push_in = -1;
    logic [31:0] push_val = '0;
    int          dut_busy_cnt = 0;

    bus_busy_responder #(
        .BaseAddress   (BASE),
        .WaitCycles    (WAIT_CYC),
        .FifoDepth     (DEPTH),
        .TimeoutCycles (TOUT)
    ) dut (
        .clk_i         (clk),
        .reset_i       (reset_i),
        .address_i     (address_i),
        .data_i        (data_i),
        .we_i          (we_i),
        .we_ram_i      (we_ram_i),
        .data_o        (data_o),
        .module_busy_o (module_busy_o),
        .push_valid_i  (push_valid_i),
        .push_data_i   (push_data_i),
        .push_ready_o  (push_ready_o),
        .fifo_count_o  (fifo_count_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [31:0] m_status();
        logic [31:0] s;
        s       = '0;
        s[0]    = (model_q.size() == 0);
        s[1]    = (model_q.size() == DEPTH);
        s[2]    = m_tout;
        s[3]    = m_ovr;
        s[15:8] = 8'(model_q.size());
        return s;
    endfunction

    // One clock edge; model FIFO pushes/pops are decided on pre-edge occupancy
    task automatic tick(input bit pop_now);
        bit do_push;
        if (push_in == 0) begin
            push_valid_i = 1'b1;
            push_data_i  = push_val;
        end
        if (push_in >= 0) push_in--;
        do_push = push_valid_i && (model_q.size() < DEPTH);
        @(posedge clk);
        #1;
        if (pop_now) void'(model_q.pop_front());
        if (do_push) model_q.push_back(push_data_i);
        push_valid_i = 1'b0;
        address_i    = '0;
        we_i         = 1'b0;
        data_i       = '0;
        we_ram_i     = '0;
        if (module_busy_o) dut_busy_cnt++;
    endtask

    task automatic push_word(input logic [31:0] v);
        push_valid_i = 1'b1;
        push_data_i  = v;
        tick(1'b0);
    endtask

    task automatic access(input logic [3:0] off, input bit wr, input logic [31:0] wd,
                          input logic [3:0] lanes, input bit intrude);
        logic [31:0] rd;
        bit          fifo_rd;
        dut_busy_cnt = 0;
        address_i = BASE + 32'(off);
        we_i      = wr;
        data_i    = wd;
        we_ram_i  = lanes;
        tick(1'b0);
        exp_busy = 1'b1;
        exp_data = '0;
        if (wr && off == 4'h0)
            for (int b = 0; b < 4; b++)
                if (lanes[b] || lanes == 4'b0000) m_scratch[8*b +: 8] = wd[8*b +: 8];
        if (wr && off == 4'hC) begin
            if (wd[2]) m_tout = 1'b0;
            if (wd[3]) m_ovr  = 1'b0;
        end
        if (intrude) begin
            address_i = BASE;
            m_ovr     = 1'b1;
        end
        for (int i = 1; i < WAIT_CYC; i++) tick(1'b0);
        fifo_rd = !wr && off == 4'h4;
        if (fifo_rd && model_q.size() == 0) begin
            tick(1'b0);
            for (int n = 0; n <= TOUT; n++) begin
                if (model_q.size() != 0) begin
                    rd = model_q[0];
                    tick(1'b1);
                    exp_data = rd;
                    break;
                end else if (n == TOUT) begin
                    tick(1'b0);
                    exp_data = '0;
                    m_tout   = 1'b1;
                    break;
                end
                tick(1'b0);
            end
        end else begin
            case (off)
                4'h0:    rd = m_scratch;
                4'h4:    rd = fifo_rd ? model_q[0] : 32'h0;
                4'h8:    rd = m_status();
                default: rd = '0;
            endcase
            if (wr) rd = '0;
            tick(fifo_rd);
            exp_data = rd;
        end
        exp_busy = 1'b0;
        tick(1'b0);
        tick(1'b0);
    endtask

    task automatic rd_reg(input logic [3:0] off);
        access(off, 1'b0, 32'h0, 4'h0, 1'b0);
    endtask

    always @(negedge clk) begin
        if (checking) begin
            check("busy", 32'(module_busy_o), 32'(exp_busy));
            check("count", 32'(fifo_count_o), 32'(model_q.size()));
            check("ready", 32'(push_ready_o), 32'(model_q.size() < DEPTH));
            if (!exp_busy) check("data", data_o, exp_data);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        check("rst_busy", 32'(module_busy_o), 32'h0);
        check("rst_data", data_o, 32'h0);
        check("rst_count", 32'(fifo_count_o), 32'h0);
        check("rst_ready", 32'(push_ready_o), 32'h1);
        @(negedge clk);
        #1;
        reset_i  = 1'b0;
        checking = 1'b1;
        tick(1'b0);

        access(4'h0, 1'b1, 32'h1234_5678, 4'b1111, 1'b0);
        check("wr_busy_len", 32'(dut_busy_cnt), 32'd2);
        rd_reg(4'h0);
        check("scratch_full", data_o, 32'h1234_5678);
        access(4'h0, 1'b1, 32'h0000_AB00, 4'b0010, 1'b0);
        rd_reg(4'h0);
        check("scratch_lane1", data_o, 32'h1234_AB78);
        access(4'h0, 1'b1, 32'hFFFF_0000, 4'b0000, 1'b0);
        rd_reg(4'h0);
        check("scratch_nolane", data_o, 32'hFFFF_0000);

        push_word(32'hA);
        push_word(32'hB);
        push_word(32'hC);
        rd_reg(4'h8);
        check("st_count3", 32'(data_o[15:8]), 32'd3);
        rd_reg(4'h4);
        check("pop_a", data_o, 32'hA);
        rd_reg(4'h4);
        check("pop_b", data_o, 32'hB);
        rd_reg(4'h4);
        check("pop_c", data_o, 32'hC);
        rd_reg(4'h8);
        check("st_count0", 32'(data_o[15:8]), 32'd0);
        check("st_empty", 32'(data_o[0]), 32'd1);

        for (int i = 0; i < DEPTH; i++) push_word(32'h100 + 32'(i));
        check("full_ready", 32'(push_ready_o), 32'd0);
        push_word(32'h999);
        check("full_count", 32'(fifo_count_o), 32'd8);
        rd_reg(4'h8);
        check("st_full", 32'(data_o[1]), 32'd1);
        for (int i = 0; i < 3; i++) begin
            rd_reg(4'h4);
            check("wrap_pop", data_o, 32'h100 + 32'(i));
        end
        for (int i = 0; i < 3; i++) push_word(32'h200 + 32'(i));
        for (int i = 0; i < DEPTH; i++) rd_reg(4'h4);
        check("wrap_last", data_o, 32'h202);

        push_val = 32'h55;
        push_in  = 10;
        rd_reg(4'h4);
        check("block_data", data_o, 32'h55);
        check("block_busy_len", 32'(dut_busy_cnt), 32'd11);

        rd_reg(4'h4);
        check("tout_busy_len", 32'(dut_busy_cnt), 32'd19);
        check("tout_data", data_o, 32'h0);
        rd_reg(4'h8);
        check("st_tout_set", 32'(data_o[2]), 32'd1);
        access(4'hC, 1'b1, 32'h4, 4'b1111, 1'b0);
        rd_reg(4'h8);
        check("st_tout_clr", 32'(data_o[2]), 32'd0);
        access(4'h0, 1'b1, 32'h0BAD_F00D, 4'b1111, 1'b1);
        rd_reg(4'h8);
        check("st_overrun", 32'(data_o[3]), 32'd1);
        rd_reg(4'hC);
        check("clear_rd", data_o, 32'h0);

        address_i = BASE + 32'h4;
        tick(1'b0);
        exp_busy = 1'b1;
        exp_data = '0;
        repeat (5) tick(1'b0);
        #2;
        reset_i = 1'b1;
        #1;
        check("arst_busy", 32'(module_busy_o), 32'h0);
        check("arst_data", data_o, 32'h0);
        check("arst_count", 32'(fifo_count_o), 32'h0);
        model_q.delete();
        m_scratch = '0;
        m_tout    = 1'b0;
        m_ovr     = 1'b0;
        exp_busy  = 1'b0;
        exp_data  = '0;
        @(negedge clk);
        #1;
        reset_i = 1'b0;
        tick(1'b0);
        rd_reg(4'h0);
        check("post_rst_scratch", data_o, 32'h0);

        checking = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
